pc_gen_unit: RTL and testbench
==============================

# pc_gen_unit

Parametrised next-PC generator with a fetch handshake. It replaces the combinational program counter at the head of the 5-stage pipeline. It holds the architectural fetch PC in a register and presents it to instruction memory over a valid/ready handshake. It selects the next PC from trap, redirect, return-address-stack prediction or sequential increment, and keeps a presented PC stable until it is accepted.

## Interface
Parameters:
- XLEN, 32, address width
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC taken on trap or misaligned redirect
- RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_write  in  1  1 = pipeline may advance; 0 = hold (hazard stall)
- pc_ready  in  1  IMEM accepts the presented PC this cycle
- pc_valid  out  1  pc_out is a valid fetch request
- pc_out  out  XLEN  current fetch PC (registered)
- redirect_valid  in  1  branch/jump resolved taken (from EX)
- redirect_target  in  XLEN  redirect destination
- trap_valid  in  1  exception/interrupt; go to TRAP_VECTOR
- ras_push  in  1  call decoded; push ras_push_addr
- ras_push_addr  in  XLEN  return address to push
- ras_pop  in  1  return predicted for the PC being accepted
- misaligned_err  out  1  one-cycle pulse: redirect_target[1:0] != 0
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

## Operation
- State machine:
  - BOOT: entered on rst. pc_valid=0.
  - FETCH: pc_valid=1.
  - HOLD: pc_valid=1, a pending target is latched.
- Transitions:
  - BOOT→FETCH unconditionally on the next cycle.
  - FETCH→HOLD on a redirect or trap while the current PC is not accepted.
  - HOLD→FETCH on accept.
- accept = pc_valid & pc_ready & pc_write.
- Next-PC priority on accept:
  1. trap (or pending trap) → TRAP_VECTOR
  2. redirect (or pending redirect) → target
  3. ras_pop with ras_count>0 → top of RAS
  4. pc_out + 4, wrapping mod 2^XLEN (32'hFFFF_FFFC → 0)
- Redirect/trap without accept: latch the target into pending_pc (trap overrides any pending redirect). pc_out stays unchanged. Enter HOLD.
  - A later redirect in HOLD overwrites the pending redirect but not a pending trap.
- Misaligned redirect (target[1:0]!=0): treated as a trap. misaligned_err=1 for exactly the cycle after redirect_valid is sampled.
- RAS is a circular buffer with a top pointer and a saturating count.
  - Push, any cycle: write at top+1 and advance top. When full, overwrite the oldest entry and keep count=RAS_DEPTH.
  - Pop: effective only on accept with count>0. It supplies the PC and decrements count. A pop with count=0 is ignored (sequential PC), no error.
  - Push and effective pop in the same cycle: the pop uses the old top, the push writes the same slot, count is unchanged.
  - Push and ineffective pop: normal push.
- Trap or redirect on accept flushes the RAS pop; push still occurs.
- pc_write=0 blocks accept only. Redirect/trap capture into HOLD still works.

## Timing
- Reset values: pc_out=RESET_VECTOR, pc_valid=0, misaligned_err=0, ras_count=0, state=BOOT, pending cleared.
- First request: pc_valid rises 1 cycle after rst deasserts, with pc_out=RESET_VECTOR.
- Latency: accept in cycle N → new pc_out visible in cycle N+1. Redirect-to-fetch latency is 1 cycle when accepted immediately.
- Handshake: while pc_valid=1 and not accepted, pc_out is stable; no exceptions.
- rst mid-HOLD: pending target discarded, RAS emptied, back to BOOT next cycle.

## Test plan
- Reset/sequential: rst 2 cycles, pc_ready=1, pc_write=1 → pc_valid=0 for 1 cycle, then pc_out 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Stall and backpressure: at pc_out=0x10, hold pc_ready=0 for 3 cycles, then pc_write=0 for 2 cycles → pc_out stays 0x10 for 5 cycles, then 0x14.
- Redirect during backpressure: pc_out=0x20, pc_ready=0, redirect to 0x400; then trap one cycle later; then pc_ready=1 → pc_out holds 0x20, then becomes 0x100 (trap wins).
- Misaligned redirect: redirect_target=0x402 with accept → misaligned_err pulses 1 cycle, next pc_out=0x100.
- RAS: push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 (depth 4), then 5 accepted pops → pc_out 0xE0, 0xD0, 0xC0, 0xB0, then sequential +4; ras_count 4→0.
- RAS simultaneous: count=2 with top 0x50; push 0x60 together with an accepted pop → next pc_out=0x50, ras_count stays 2, next pop yields 0x60.

Source files
------------

// File: rtl/pc_gen_unit_if.sv
// Fetch-side bundle between the next-PC generator and the pipeline/IMEM.
// Handshake: a fetch request (pc_valid, pc_out) is accepted on a rising clk edge when
// pc_valid & pc_ready & pc_write are all high; until then pc_out is held stable.
interface pc_gen_unit_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic            pc_write;
  logic            pc_ready;
  logic            pc_valid;
  logic [XLEN-1:0] pc_out;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic            ras_push;
  logic [XLEN-1:0] ras_push_addr;
  logic            ras_pop;
  logic            misaligned_err;
  logic [CW-1:0]   ras_count;

  modport master (
    input  pc_write, pc_ready, redirect_valid, redirect_target, trap_valid,
           ras_push, ras_push_addr, ras_pop,
    output pc_valid, pc_out, misaligned_err, ras_count
  );

  modport slave (
    output pc_write, pc_ready, redirect_valid, redirect_target, trap_valid,
           ras_push, ras_push_addr, ras_pop,
    input  pc_valid, pc_out, misaligned_err, ras_count
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Registered fetch PC with trap/redirect/RAS/sequential next-PC selection and a
// valid/ready request that stays stable until accepted.
module pc_gen_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  pc_gen_unit_if.master bus,
  output logic [1:0]    dbg_state
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_trap_q, pend_trap_d;
  logic            mis_q, mis_d;
  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];

  logic            pc_valid;
  logic            misaligned;
  logic            new_trap;
  logic            new_redir;
  logic            accept;
  logic            pop_eff;
  logic [PW-1:0]   top_inc;

  always_comb begin
    pc_valid   = (state_q != BOOT);
    misaligned = |bus.redirect_target[1:0];
    // A misaligned redirect is handled exactly like a trap.
    new_trap   = bus.trap_valid | (bus.redirect_valid & misaligned);
    new_redir  = bus.redirect_valid & ~misaligned;
    accept     = pc_valid & bus.pc_ready & bus.pc_write;
    // Any control-flow change on accept flushes the predicted return.
    pop_eff    = accept & bus.ras_pop & (cnt_q != '0)
               & ~(new_trap | new_redir | pend_valid_q);
    top_inc    = top_q + PW'(1);
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    pend_trap_d  = pend_trap_q;
    mis_d        = bus.redirect_valid & misaligned;

    if (state_q == BOOT) begin
      state_d = FETCH;
    end else if (accept) begin
      state_d      = FETCH;
      pend_valid_d = 1'b0;
      pend_trap_d  = 1'b0;
      if (new_trap)          pc_d = TRAP_VECTOR;
      else if (pend_trap_q)  pc_d = pend_pc_q;
      else if (new_redir)    pc_d = bus.redirect_target;
      else if (pend_valid_q) pc_d = pend_pc_q;
      else if (pop_eff)      pc_d = ras_q[top_q];
      else                   pc_d = pc_q + XLEN'(4);
    end else if (new_trap | new_redir) begin
      state_d = HOLD;
      if (new_trap) begin
        pend_valid_d = 1'b1;
        pend_trap_d  = 1'b1;
        pend_pc_d    = TRAP_VECTOR;
      end else if (!pend_trap_q) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = bus.redirect_target;
      end
    end
  end

  // A pop and a push together reuse the popped slot, so top and count stay put.
  always_comb begin
    ras_d = ras_q;
    top_d = top_q;
    cnt_d = cnt_q;
    if (pop_eff && bus.ras_push) begin
      ras_d[top_q] = bus.ras_push_addr;
    end else if (pop_eff) begin
      top_d = top_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end else if (bus.ras_push) begin
      top_d          = top_inc;
      ras_d[top_inc] = bus.ras_push_addr;
      if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_trap_q  <= 1'b0;
      mis_q        <= 1'b0;
      top_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_trap_q  <= pend_trap_d;
      mis_q        <= mis_d;
      top_q        <= top_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign bus.pc_valid       = pc_valid;
  assign bus.pc_out         = pc_q;
  assign bus.misaligned_err = mis_q;
  assign bus.ras_count      = cnt_q;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: reset, sequencing, stalls, redirect/trap capture,
// misaligned redirects and return-address-stack behaviour.
module tb_pc_gen_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  always #5 clk = ~clk;

  pc_gen_unit_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

  pc_gen_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pc_write = 1'b1; bus.pc_ready = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_target = '0; bus.trap_valid = 1'b0;
    bus.ras_push = 1'b0; bus.ras_push_addr = '0; bus.ras_pop = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [4];
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
    idle_inputs();
    rst = 1'b1;
    step(); step();
    n_checks++; if (bus.pc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", bus.pc_valid); end
    n_checks++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=0", bus.pc_out); end
    n_checks++; if (bus.ras_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", bus.ras_count); end
    n_checks++; if (bus.misaligned_err !== 1'b0) begin n_fail++; $display("FAIL rst_mis got=%b exp=0", bus.misaligned_err); end
    n_checks++; if (dbg_state !== S_BOOT) begin n_fail++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_BOOT); end
    rst = 1'b0;
    step();
    n_checks++; if (bus.pc_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got=%b exp=1", bus.pc_valid); end
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      n_checks++;
      if (bus.pc_out !== exp_seq[i]) begin n_fail++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pc_out, exp_seq[i]); end
    end
  endtask

  task automatic test_stall();
    step();
    n_checks++; if (bus.pc_out !== 32'h10) begin n_fail++; $display("FAIL stall_start got=%h exp=10", bus.pc_out); end
    bus.pc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin bus.pc_ready = 1'b1; bus.pc_write = 1'b0; end
      step();
      n_checks++;
      if (bus.pc_out !== 32'h10 || bus.pc_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d] got=%h/%b exp=10/1", i, bus.pc_out, bus.pc_valid);
      end
    end
    bus.pc_write = 1'b1;
    step();
    n_checks++; if (bus.pc_out !== 32'h14) begin n_fail++; $display("FAIL stall_release got=%h exp=14", bus.pc_out); end
  endtask

  task automatic test_trap_in_hold();
    step(); step(); step();
    n_checks++; if (bus.pc_out !== 32'h20) begin n_fail++; $display("FAIL hold_start got=%h exp=20", bus.pc_out); end
    bus.pc_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h400;
    step();
    n_checks++; if (bus.pc_out !== 32'h20) begin n_fail++; $display("FAIL hold_redir_pc got=%h exp=20", bus.pc_out); end
    n_checks++; if (dbg_state !== S_HOLD) begin n_fail++; $display("FAIL hold_state got=%0d exp=%0d", dbg_state, S_HOLD); end
    bus.redirect_valid = 1'b0; bus.trap_valid = 1'b1;
    step();
    n_checks++; if (bus.pc_out !== 32'h20) begin n_fail++; $display("FAIL hold_trap_pc got=%h exp=20", bus.pc_out); end
    bus.trap_valid = 1'b0; bus.pc_ready = 1'b1;
    step();
    n_checks++; if (bus.pc_out !== 32'h100) begin n_fail++; $display("FAIL trap_wins got=%h exp=100", bus.pc_out); end
    n_checks++; if (dbg_state !== S_FETCH) begin n_fail++; $display("FAIL hold_exit got=%0d exp=%0d", dbg_state, S_FETCH); end
  endtask

  task automatic test_redirect();
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h200;
    step();
    n_checks++; if (bus.pc_out !== 32'h200) begin n_fail++; $display("FAIL redir_now got=%h exp=200", bus.pc_out); end
    bus.pc_ready = 1'b0; bus.redirect_target = 32'h300;
    step();
    bus.redirect_target = 32'h340;
    step();
    n_checks++; if (bus.pc_out !== 32'h200) begin n_fail++; $display("FAIL redir_hold got=%h exp=200", bus.pc_out); end
    bus.redirect_valid = 1'b0; bus.pc_ready = 1'b1;
    step();
    n_checks++; if (bus.pc_out !== 32'h340) begin n_fail++; $display("FAIL redir_overwrite got=%h exp=340", bus.pc_out); end
  endtask

  task automatic test_misaligned();
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h402;
    step();
    n_checks++; if (bus.pc_out !== 32'h100) begin n_fail++; $display("FAIL mis_pc got=%h exp=100", bus.pc_out); end
    n_checks++; if (bus.misaligned_err !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got=%b exp=1", bus.misaligned_err); end
    bus.redirect_valid = 1'b0;
    step();
    n_checks++; if (bus.misaligned_err !== 1'b0) begin n_fail++; $display("FAIL mis_clear got=%b exp=0", bus.misaligned_err); end
    n_checks++; if (bus.pc_out !== 32'h104) begin n_fail++; $display("FAIL mis_next got=%h exp=104", bus.pc_out); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] push_v [5];
    logic [2:0]  cnt_v  [5];
    logic [31:0] pop_pc [5];
    logic [2:0]  pop_c  [5];
    push_v = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0};
    cnt_v  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    pop_pc = '{32'hE0, 32'hD0, 32'hC0, 32'hB0, 32'hB4};
    pop_c  = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    bus.pc_ready = 1'b0; bus.ras_push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.ras_push_addr = push_v[i];
      step();
      n_checks++;
      if (bus.ras_count !== cnt_v[i]) begin n_fail++; $display("FAIL ras_push_cnt[%0d] got=%0d exp=%0d", i, bus.ras_count, cnt_v[i]); end
    end
    bus.ras_push = 1'b0; bus.pc_ready = 1'b1; bus.ras_pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (bus.pc_out !== pop_pc[i] || bus.ras_count !== pop_c[i]) begin
        n_fail++; $display("FAIL ras_pop[%0d] got=%h/%0d exp=%h/%0d", i, bus.pc_out, bus.ras_count, pop_pc[i], pop_c[i]);
      end
    end
    bus.ras_pop = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.pc_ready = 1'b0; bus.ras_push = 1'b1; bus.ras_push_addr = 32'h40;
    step();
    bus.ras_push_addr = 32'h50;
    step();
    n_checks++; if (bus.ras_count !== 3'd2) begin n_fail++; $display("FAIL b2b_setup got=%0d exp=2", bus.ras_count); end
    bus.pc_ready = 1'b1; bus.ras_pop = 1'b1; bus.ras_push_addr = 32'h60;
    step();
    n_checks++; if (bus.pc_out !== 32'h50 || bus.ras_count !== 3'd2) begin n_fail++; $display("FAIL b2b_pushpop got=%h/%0d exp=50/2", bus.pc_out, bus.ras_count); end
    bus.ras_push = 1'b0;
    step();
    n_checks++; if (bus.pc_out !== 32'h60 || bus.ras_count !== 3'd1) begin n_fail++; $display("FAIL b2b_pop1 got=%h/%0d exp=60/1", bus.pc_out, bus.ras_count); end
    step();
    n_checks++; if (bus.pc_out !== 32'h40 || bus.ras_count !== 3'd0) begin n_fail++; $display("FAIL b2b_pop2 got=%h/%0d exp=40/0", bus.pc_out, bus.ras_count); end
    bus.ras_pop = 1'b0;
  endtask

  task automatic test_flush();
    bus.pc_ready = 1'b0; bus.ras_push = 1'b1; bus.ras_push_addr = 32'h70;
    step();
    bus.ras_push = 1'b0; bus.pc_ready = 1'b1; bus.ras_pop = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h500;
    step();
    n_checks++; if (bus.pc_out !== 32'h500 || bus.ras_count !== 3'd1) begin n_fail++; $display("FAIL flush_pop got=%h/%0d exp=500/1", bus.pc_out, bus.ras_count); end
    bus.redirect_valid = 1'b0; bus.ras_pop = 1'b0;
  endtask

  task automatic test_reset_hold();
    bus.pc_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h600;
    step();
    n_checks++; if (dbg_state !== S_HOLD) begin n_fail++; $display("FAIL rh_hold got=%0d exp=%0d", dbg_state, S_HOLD); end
    bus.redirect_valid = 1'b0; rst = 1'b1;
    step();
    n_checks++; if (bus.pc_valid !== 1'b0 || bus.pc_out !== 32'h0 || bus.ras_count !== 3'd0 || dbg_state !== S_BOOT) begin
      n_fail++; $display("FAIL rh_reset got=%b/%h/%0d/%0d exp=0/0/0/0", bus.pc_valid, bus.pc_out, bus.ras_count, dbg_state);
    end
    rst = 1'b0;
    step();
    n_checks++; if (bus.pc_valid !== 1'b1 || bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL rh_boot got=%b/%h exp=1/0", bus.pc_valid, bus.pc_out); end
    bus.pc_ready = 1'b1;
    step();
    n_checks++; if (bus.pc_out !== 32'h4) begin n_fail++; $display("FAIL rh_discard got=%h exp=4", bus.pc_out); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_trap_in_hold();
    test_redirect();
    test_misaligned();
    test_ras_overflow();
    test_back_to_back();
    test_flush();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
